// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration-chain writer, the host-side
// bitstream packer and the bench: FSM encoding and word/padding arithmetic.
package cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    FINISH
  } cfg_state_e;

  // Number of host words needed to cover the whole chain.
  function automatic int unsigned cfg_n_words(input int unsigned chain_len,
                                              input int unsigned w);
    return (chain_len + w - 1) / w;
  endfunction

  // Unused high bits of the first word; they are discarded, never shifted.
  function automatic int unsigned cfg_pad_bits(input int unsigned chain_len,
                                               input int unsigned w);
    return cfg_n_words(chain_len, w) * w - chain_len;
  endfunction

endpackage

// File: rtl/cfg_clk_div.sv
// Dwell-time counter for the shift/latch phases: LOAD starts a CLK_DIV-cycle
// interval, EXPIRE is high on the last cycle of it.
module cfg_clk_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic LOAD,
  output logic EXPIRE
);

  localparam int unsigned   CW     = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (LOAD) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign EXPIRE = (cnt == '0);

endmodule

// File: rtl/cfg_chain_writer.sv
// Host-word to bit-serial writer for the external configuration shift chain:
// shifts CHAIN_LEN bits MSB-first, pulses the storage latch, enables outputs.
module cfg_chain_writer
  import cfg_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned W         = 8,
  parameter int unsigned CLK_DIV   = 2
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic [W-1:0] WORD,
  input  logic         WORD_VALID,
  output logic         WORD_READY,
  output logic         BUSY,
  output logic         DONE,
  output logic         CFG_SDO,
  output logic         CFG_SCK,
  output logic         CFG_LATCH,
  output logic         CFG_OE_N
);

  localparam int unsigned    P         = cfg_pad_bits(CHAIN_LEN, W);
  localparam int unsigned    BCW       = $clog2(CHAIN_LEN + 1);
  localparam int unsigned    WBW       = $clog2(W + 1);
  localparam logic [BCW-1:0] BITS_FULL = BCW'(CHAIN_LEN);
  localparam logic [WBW-1:0] WB_FIRST  = WBW'(W - P);
  localparam logic [WBW-1:0] WB_FULL   = WBW'(W);

  cfg_state_e     state, state_next;
  logic [BCW-1:0] bit_cnt;
  logic [WBW-1:0] wb_cnt;
  logic [W-1:0]   sreg;
  logic [W-1:0]   aligned;
  logic [W-1:0]   shifted;
  logic           first_word;
  logic           last_bit;
  logic           word_done;
  logic           div_load;
  logic           div_expire;

  logic busy_d, done_d, sdo_d, sck_d, latch_d, oe_n_d;

  // The first word of a frame is pre-shifted so its padding falls off the top.
  assign first_word = (bit_cnt == BITS_FULL);
  assign aligned    = first_word ? (WORD << P) : WORD;
  assign shifted    = sreg << 1;
  assign last_bit   = (bit_cnt == BCW'(1));
  assign word_done  = (wb_cnt == WBW'(1));

  assign WORD_READY = (state == FETCH);

  cfg_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .CLK   (CLK),
    .RST_N (RST_N),
    .LOAD  (div_load),
    .EXPIRE(div_expire)
  );

  assign div_load = (state_next != state);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (START) state_next = FETCH;
      FETCH:    if (WORD_VALID) state_next = SHIFT_LO;
      SHIFT_LO: if (div_expire) state_next = SHIFT_HI;
      SHIFT_HI: begin
        if (div_expire) begin
          if (last_bit) begin
            state_next = LATCH;
          end else if (word_done) begin
            state_next = FETCH;
          end else begin
            state_next = SHIFT_LO;
          end
        end
      end
      LATCH:    if (div_expire) state_next = FINISH;
      FINISH:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change
  // on the same edge as the state they belong to.
  always_comb begin
    busy_d  = (state_next != IDLE);
    done_d  = (state_next == FINISH);
    sck_d   = (state_next == SHIFT_HI);
    latch_d = (state_next == LATCH);

    oe_n_d = CFG_OE_N;
    if (state == IDLE && state_next == FETCH) begin
      oe_n_d = 1'b1;
    end else if (state_next == FINISH) begin
      oe_n_d = 1'b0;
    end

    sdo_d = CFG_SDO;
    if (state_next == SHIFT_LO && state != SHIFT_LO) begin
      sdo_d = (state == FETCH) ? aligned[W-1] : shifted[W-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      CFG_SDO   <= 1'b0;
      CFG_SCK   <= 1'b0;
      CFG_LATCH <= 1'b0;
      CFG_OE_N  <= 1'b1;
    end else begin
      BUSY      <= busy_d;
      DONE      <= done_d;
      CFG_SDO   <= sdo_d;
      CFG_SCK   <= sck_d;
      CFG_LATCH <= latch_d;
      CFG_OE_N  <= oe_n_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      bit_cnt <= '0;
      wb_cnt  <= '0;
      sreg    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (START) bit_cnt <= BITS_FULL;
        end
        FETCH: begin
          if (WORD_VALID) begin
            sreg   <= aligned;
            wb_cnt <= first_word ? WB_FIRST : WB_FULL;
          end
        end
        SHIFT_HI: begin
          if (div_expire) begin
            bit_cnt <= bit_cnt - BCW'(1);
            wb_cnt  <= wb_cnt - WBW'(1);
            sreg    <= shifted;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_chain_writer.sv
// Scoreboard bench for cfg_chain_writer: three configurations share one clock,
// stimulus pushes expected chain events, a monitor pops and compares them.
module tb_cfg_chain_writer;
  import cfg_pkg::*;

  localparam int EV_RST   = 0;
  localparam int EV_BIT   = 1;
  localparam int EV_LATCH = 2;
  localparam int EV_DONE  = 3;
  localparam int EV_OE    = 4;
  localparam int EV_BUSY  = 5;

  typedef struct {
    int g;
    int kind;
    int val;
  } ev_t;

  logic       clk = 1'b0;
  logic [2:0] rst_n = '0;
  logic [2:0] start = '0;
  logic [2:0] valid = '0;
  logic [7:0] word_in [3];
  logic [2:0] ready, busy, done, sdo, sck, latch, oe_n;

  int   cyc = 0;
  int   start_cyc [3] = '{0, 0, 0};
  int   nbits [3] = '{0, 0, 0};
  int   n_vec = 0;
  int   n_err = 0;
  ev_t  exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cfg_chain_writer #(.CHAIN_LEN(12), .W(8), .CLK_DIV(1)) u_dut0 (
    .CLK(clk), .RST_N(rst_n[0]), .START(start[0]), .WORD(word_in[0]),
    .WORD_VALID(valid[0]), .WORD_READY(ready[0]), .BUSY(busy[0]), .DONE(done[0]),
    .CFG_SDO(sdo[0]), .CFG_SCK(sck[0]), .CFG_LATCH(latch[0]), .CFG_OE_N(oe_n[0]));

  cfg_chain_writer #(.CHAIN_LEN(16), .W(8), .CLK_DIV(3)) u_dut1 (
    .CLK(clk), .RST_N(rst_n[1]), .START(start[1]), .WORD(word_in[1]),
    .WORD_VALID(valid[1]), .WORD_READY(ready[1]), .BUSY(busy[1]), .DONE(done[1]),
    .CFG_SDO(sdo[1]), .CFG_SCK(sck[1]), .CFG_LATCH(latch[1]), .CFG_OE_N(oe_n[1]));

  cfg_chain_writer #(.CHAIN_LEN(1), .W(8), .CLK_DIV(1)) u_dut2 (
    .CLK(clk), .RST_N(rst_n[2]), .START(start[2]), .WORD(word_in[2]),
    .WORD_VALID(valid[2]), .WORD_READY(ready[2]), .BUSY(busy[2]), .DONE(done[2]),
    .CFG_SDO(sdo[2]), .CFG_SCK(sck[2]), .CFG_LATCH(latch[2]), .CFG_OE_N(oe_n[2]));

  function automatic int cd_of(input int g);
    return (g == 1) ? 3 : 1;
  endfunction

  function automatic string kname(input int k);
    case (k)
      EV_RST:   return "reset_state";
      EV_BIT:   return "sdo_bit";
      EV_LATCH: return "latch_cycle";
      EV_DONE:  return "done_cycle";
      EV_OE:    return "oe_n_level";
      EV_BUSY:  return "busy_edge";
      default:  return "unknown";
    endcase
  endfunction

  task automatic expect_ev(input int g, input int kind, input int val);
    exp_q.push_back('{g, kind, val});
  endtask

  // ---------------- monitor ----------------
  logic [2:0] rst_d   = '1;
  logic [2:0] sck_p   = '0;
  logic [2:0] sdo_p   = '0;
  logic [2:0] latch_p = '0;
  logic [2:0] oe_p    = '1;
  logic [2:0] busy_p  = '0;
  int hi_len [3]     = '{0, 0, 0};
  int lat_len [3]    = '{0, 0, 0};
  int stable [3]     = '{1000, 1000, 1000};
  int since_rise [3] = '{1000, 1000, 1000};

  always @(posedge clk) rst_d <= rst_n;

  task automatic observe(input int g, input int kind, input int val);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s dut%0d: observed %0d, required no further event", kname(kind), g, val);
    end else begin
      e = exp_q.pop_front();
      if (e.g != g || e.kind != kind || e.val != val) begin
        n_err++;
        $display("FAIL %s dut%0d: observed dut%0d %s=%0d, required dut%0d %s=%0d",
                 kname(e.kind), e.g, g, kname(kind), val, e.g, kname(e.kind), e.val);
      end
    end
  endtask

  task automatic chk(input string name, input int g, input int got, input int req, input bit at_least);
    n_vec++;
    if (at_least ? (got < req) : (got != req)) begin
      n_err++;
      $display("FAIL %s dut%0d: observed %0d, required %s%0d", name, g, got, at_least ? ">=" : "", req);
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      int rel;
      int cd;
      rel = cyc - start_cyc[g] + 1;
      cd  = cd_of(g);
      if (!rst_d[g]) begin
        observe(g, EV_RST, int'({busy[g], done[g], ready[g], sdo[g], sck[g], latch[g], oe_n[g]}));
      end else begin
        if (sck[g] && !sck_p[g]) begin
          chk("sdo_setup", g, stable[g], cd, 1'b1);
          observe(g, EV_BIT, int'(sdo[g]));
          nbits[g]++;
        end
        if (!sck[g] && sck_p[g]) chk("sck_high_width", g, hi_len[g], cd, 1'b0);
        if (sdo[g] != sdo_p[g]) chk("sdo_hold", g, since_rise[g], cd, 1'b1);
        if (latch[g] && !latch_p[g]) observe(g, EV_LATCH, rel);
        if (!latch[g] && latch_p[g]) chk("latch_width", g, lat_len[g], cd, 1'b0);
        if (done[g]) observe(g, EV_DONE, rel);
        if (oe_n[g] != oe_p[g]) observe(g, EV_OE, int'(oe_n[g]));
        if (busy[g] != busy_p[g]) observe(g, EV_BUSY, int'(busy[g]) * 1000 + rel);
      end
      if (sck[g] && !sck_p[g]) begin
        hi_len[g] = 1;
        since_rise[g] = 1;
      end else begin
        if (sck[g]) hi_len[g]++;
        since_rise[g]++;
      end
      if (latch[g] && !latch_p[g]) lat_len[g] = 1;
      else if (latch[g]) lat_len[g]++;
      if (sdo[g] != sdo_p[g]) stable[g] = 1;
      else stable[g]++;
      sck_p[g]   = sck[g];
      sdo_p[g]   = sdo[g];
      latch_p[g] = latch[g];
      oe_p[g]    = oe_n[g];
      busy_p[g]  = busy[g];
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready(input int g);
    int i;
    i = 0;
    while (!ready[g] && i < 500) begin
      @(negedge clk);
      i++;
    end
    if (!ready[g]) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout dut%0d: WORD_READY=0 after 500 cycles, required 1", g);
    end
  endtask

  task automatic wait_done(input int g);
    int i;
    i = 0;
    while (!done[g] && i < 2000) begin
      @(negedge clk);
      i++;
    end
    if (!done[g]) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout dut%0d: DONE=0 after 2000 cycles, required 1", g);
    end
  endtask

  // Expected event sequence for one frame; bits_val holds the chain MSB-first.
  task automatic exp_frame(input int g, input logic [63:0] bits_val, input int nb,
                           input int done_rel, input bit oe_was_low, input bit aborted);
    if (oe_was_low) expect_ev(g, EV_OE, 1);
    expect_ev(g, EV_BUSY, 1002);
    for (int i = 0; i < nb; i++) expect_ev(g, EV_BIT, int'(bits_val[nb-1-i]));
    if (aborted) begin
      expect_ev(g, EV_RST, 1);
    end else begin
      expect_ev(g, EV_LATCH, done_rel - cd_of(g));
      expect_ev(g, EV_DONE, done_rel);
      expect_ev(g, EV_OE, 0);
      expect_ev(g, EV_BUSY, done_rel + 1);
    end
  endtask

  task automatic run_frame(input int g, input logic [7:0] w0, input logic [7:0] w1,
                           input int nw, input int stall, input bit poke, input int abort_after);
    int nb0;
    int i;
    @(negedge clk);
    nb0          = nbits[g];
    start[g]     = 1'b1;
    start_cyc[g] = cyc;
    word_in[g]   = w0;
    valid[g]     = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    for (int k = 0; k < nw; k++) begin
      if (k > 0) begin
        if (stall > 0) begin
          valid[g] = 1'b0;
          wait_ready(g);
          repeat (stall) @(negedge clk);
        end
        word_in[g] = w1;
        valid[g]   = 1'b1;
      end
      wait_ready(g);
      @(negedge clk);
      if (k == 0 && poke) begin
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
      end
    end
    valid[g] = 1'b0;
    if (abort_after > 0) begin
      i = 0;
      while (nbits[g] < nb0 + abort_after && i < 500) begin
        @(negedge clk);
        i++;
      end
      if (nbits[g] < nb0 + abort_after) begin
        n_vec++;
        n_err++;
        $display("FAIL bit_timeout dut%0d: %0d bits shifted, required %0d", g, nbits[g] - nb0, abort_after);
      end
      rst_n[g] = 1'b0;
      @(negedge clk);
      rst_n[g] = 1'b1;
    end else begin
      wait_done(g);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int g = 0; g < 3; g++) word_in[g] = 8'h00;
    for (int c = 0; c < 2; c++)
      for (int g = 0; g < 3; g++) expect_ev(g, EV_RST, 1);
    repeat (2) @(negedge clk);
    rst_n = '1;

    exp_frame(0, 64'hABC, 12, 29, 1'b0, 1'b0);
    run_frame(0, 8'h0A, 8'hBC, 2, 0, 1'b0, 0);

    exp_frame(0, 64'hABC, 12, 34, 1'b1, 1'b0);
    run_frame(0, 8'h0A, 8'hBC, 2, 5, 1'b0, 0);

    exp_frame(0, 64'hABC, 12, 29, 1'b1, 1'b0);
    run_frame(0, 8'h0A, 8'hBC, 2, 0, 1'b1, 0);

    exp_frame(0, 64'h15, 5, 0, 1'b1, 1'b1);
    run_frame(0, 8'h0A, 8'hBC, 2, 0, 1'b0, 5);

    exp_frame(0, 64'hABC, 12, 29, 1'b0, 1'b0);
    run_frame(0, 8'h0A, 8'hBC, 2, 0, 1'b0, 0);

    exp_frame(1, 64'hFF00, 16, 103, 1'b0, 1'b0);
    run_frame(1, 8'hFF, 8'h00, 2, 0, 1'b0, 0);

    exp_frame(2, 64'h1, 1, 6, 1'b0, 1'b0);
    run_frame(2, 8'h81, 8'h00, 1, 0, 1'b0, 0);

    repeat (5) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_events: %0d expected events never observed, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cfg_chain_writer.md
# cfg_chain_writer

Serial configuration writer for the slice/IOB fabric. Accepts configuration words from a host over a valid/ready stream and shifts them bit-serially into the external configuration shift chain, i.e. discrete 74HC595-style registers holding every slice's LUT INIT and FF_USED bits and every IOB's INPUT/OUTPUT/ENABLE_USED bits. It then pulses the storage latch and releases the fabric outputs. It is the writer end of the chain that the LUT and IOB primitives read from.

## Interface
- `CHAIN_LEN`, 64: total configuration bits in the chain (≥1).
- `W`, 8: host word width (≥1).
- `CLK_DIV`, 2: CLK cycles per half-period of `CFG_SCK` (≥1).

- `CLK` in 1: single clock; every flop is on its rising edge.
- `RST_N` in 1: reset, synchronous and active-low.
- `START` in 1: single-cycle request to begin a frame.
- `WORD` in W: host configuration word.
- `WORD_VALID` in 1: `WORD` valid.
- `WORD_READY` out 1: writer accepts `WORD` this cycle.
- `BUSY` out 1: frame in progress.
- `DONE` out 1: one-cycle pulse when the frame completes.
- `CFG_SDO` out 1: chain serial data.
- `CFG_SCK` out 1: chain shift clock; the chain samples `CFG_SDO` on its rising edge.
- `CFG_LATCH` out 1: storage latch strobe; the chain latches on its rising edge.
- `CFG_OE_N` out 1: fabric output enable, active-low.

## Operation
- States: IDLE, FETCH, SHIFT_LO, SHIFT_HI, LATCH, FINISH.
- IDLE:
  - `BUSY`=0.
  - `START`=1 → FETCH.
  - On entry to FETCH: bit counter = CHAIN_LEN, `CFG_OE_N`←1. Outputs stay disabled until the frame completes.
- FETCH:
  - `WORD_READY`=1.
  - On `WORD_VALID`&&`WORD_READY`: load the shift register → SHIFT_LO.
  - Without `WORD_VALID`: wait indefinitely. `CFG_SCK` stays 0.
- Bit order:
  - Chain bit CHAIN_LEN-1 is sent first; bit 0 is sent last.
  - Words arrive highest-first. Within a word, MSB first.
  - N_WORDS = ceil(CHAIN_LEN/W). P = N_WORDS·W − CHAIN_LEN.
  - The top P bits of the first word are discarded and never shifted. Only its low W−P bits are sent.
- SHIFT_LO:
  - `CFG_SDO` = current bit, `CFG_SCK`=0 for CLK_DIV cycles → SHIFT_HI.
- SHIFT_HI:
  - `CFG_SCK`=1 for CLK_DIV cycles; `CFG_SDO` held stable.
  - Then decrement the bit counter and advance the word bit.
  - Exit: if bit counter = 0 → LATCH; else if the word is exhausted → FETCH; else → SHIFT_LO.
- LATCH:
  - `CFG_SCK`=0, `CFG_LATCH`=1 for CLK_DIV cycles → FINISH.
- FINISH:
  - `CFG_LATCH`=0, `CFG_OE_N`←0, `DONE`=1 for one cycle → IDLE.
- `START` while `BUSY`: ignored, with no effect on the frame.
- `WORD_VALID` outside FETCH: ignored; `WORD_READY`=0.
- Counter widths:
  - Bit counter: $clog2(CHAIN_LEN+1).
  - Divider: $clog2(CLK_DIV+1).
  - Word-bit index: $clog2(W+1).

## Timing
- Reset values:
  - State IDLE.
  - `BUSY`=0, `DONE`=0, `WORD_READY`=0.
  - `CFG_SDO`=0, `CFG_SCK`=0, `CFG_LATCH`=0.
  - `CFG_OE_N`=1. Outputs stay disabled after reset until the first complete frame.
- `RST_N`=0 mid-frame: same values on the next edge. The partial frame is abandoned, no latch pulse is issued, and `CFG_OE_N` stays 1.
- All outputs are registered; no combinational path runs from input to output except `WORD_READY`, which is a function of state only.
- `BUSY`:
  - Rises the cycle after `START` is sampled.
  - Falls the cycle after `DONE`.
- Frame length with no host stalls: 1 + N_WORDS (FETCH) + 2·CLK_DIV·CHAIN_LEN + CLK_DIV (LATCH) + 1 (FINISH) cycles.
- `CFG_SDO` changes only on the cycle `CFG_SCK` goes 0. This gives CLK_DIV cycles of setup and CLK_DIV cycles of hold around each rising `CFG_SCK`.
- Host stall: `CFG_SCK` stays 0 and `CFG_SDO` holds its last value.

## Structure
- Shared package `cfg_pkg`:
  - State encoding (localparams or enum).
  - N_WORDS/P derivation functions, reused by the host-side bitstream packer and by the testbench.
- One natural sub-module: `cfg_clk_div`. It is a CLK_DIV down-counter with load/expire, driving the SHIFT_LO, SHIFT_HI and LATCH dwell times.

## Test plan
- CHAIN_LEN=12, W=8, CLK_DIV=1, words 0x0A then 0xBC, no stalls:
  - `CFG_SDO` sampled at 12 `CFG_SCK` rising edges = 1010_1011_1100 (0xABC).
  - Then one `CFG_LATCH` pulse, `DONE` at cycle 1+2+24+1+1=29, `CFG_OE_N` 1→0.
- Same frame, `WORD_VALID` withheld 5 cycles before the second word:
  - `CFG_SCK` stays 0 during the wait.
  - Sampled bits unchanged; `DONE` 5 cycles later.
- CHAIN_LEN=16, W=8, CLK_DIV=3, words 0xFF, 0x00:
  - Each `CFG_SCK` high/low lasts exactly 3 cycles.
  - `CFG_SDO` stable ≥3 cycles before and after each rising edge.
- `START` re-asserted mid-frame:
  - No restart; bit count and `DONE` timing identical to the unperturbed run.
- `RST_N` low for 1 cycle after 5 bits shifted:
  - All outputs at reset values next cycle, no `CFG_LATCH`, `CFG_OE_N`=1.
  - A subsequent full frame completes correctly.
- CHAIN_LEN=1, W=8, word 0x81:
  - Exactly one `CFG_SCK` edge, with `CFG_SDO`=1 (the LSB; the top 7 bits are discarded).
  - Then latch and `DONE`.
